// File: rtl/sha256_rolled_miner_pkg.sv
// sha256_rolled_miner_pkg: SHA-256 constants, round/schedule functions and miner FSM states
package sha256_rolled_miner_pkg;
  localparam int PASS_CYCLES = 68;
  localparam logic [31:0] PAD_ONE = 32'h8000_0000;
  localparam logic [31:0] LEN_640 = 32'h0000_0280;
  localparam logic [31:0] LEN_256 = 32'h0000_0100;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };
  // H7 == 0 exactly when the final h register equals -IV[7]
  localparam logic [31:0] H7_TARGET = 32'h0 - IV[7];
  typedef enum logic [1:0] {IDLE, PASS0, PASS1, CHECK} state_t;
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] e0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction
  function automatic logic [31:0] e1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
endpackage

// File: rtl/sha256_rolled_miner_msg_sched.sv
// sha256_rolled_miner_msg_sched: 16-deep message schedule shift register with block load and expansion
module sha256_rolled_miner_msg_sched (
  input  logic              clk,
  input  logic              load,
  input  logic              shift,
  input  logic [15:0][31:0] load_w,
  output logic [31:0]       w_t
);
  import sha256_rolled_miner_pkg::*;
  logic [15:0][31:0] w;
  logic [31:0] w_new;
  assign w_t = w[0];
  assign w_new = s1(w[14]) + w[9] + s0(w[1]) + w[0];
  // w[0] is the word consumed by the current round; each round appends W[t+16]
  always_ff @(posedge clk)
    if (load) w <= load_w;
    else if (shift) w <= {w_new, w[15:1]};
endmodule

// File: rtl/sha256_rolled_miner.sv
// sha256_rolled_miner: rolled double-SHA256 nonce scanner; MINER_DIFF_CHECK_EN adds an H6 difficulty mask
module sha256_rolled_miner #(
  parameter int CORE_ID = 0,
  parameter int NUM_CORES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [255:0] midstate,
  input  logic [95:0]  data_tail,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [31:0]  diff_mask,
  output logic         busy,
  output logic         done,
  output logic [31:0]  nonce_cur,
  output logic         golden_valid,
  output logic [31:0]  golden_nonce,
  input  logic         golden_ack,
  output logic         golden_overflow
);
  import sha256_rolled_miner_pkg::*;
  state_t state;
  logic [6:0] cnt;
  logic skip;
  logic [7:0][31:0] mid_q, st, st_next, hbuf;
  logic [95:0] tail_q;
  logic [31:0] end_q, w_t, kt, t1, t2;
  logic [15:0][31:0] load_w;
  logic [32:0] first, nxt;
  logic start_go, hashing, ld, rnd, pass_end, empty, last, hit;
  assign start_go = state == IDLE && start && !abort;
  assign hashing = state == PASS0 || state == PASS1;
  assign ld = hashing && cnt == 7'd1;
  assign rnd = hashing && cnt >= 7'd4;
  assign pass_end = cnt == 7'(PASS_CYCLES - 1);
  assign first = {1'b0, nonce_start} + 33'(CORE_ID);
  assign nxt = {1'b0, nonce_cur} + 33'(NUM_CORES);
  assign empty = first[32] || first[31:0] > nonce_end;
  assign last = nxt[32] || nxt[31:0] > end_q;
  assign kt = K[6'(cnt - 7'd4)];
  assign t1 = st[7] + e1(st[4]) + ch(st[4], st[5], st[6]) + kt + w_t;
  assign t2 = e0(st[0]) + maj(st[0], st[1], st[2]);
  assign st_next = {st[6], st[5], st[4], st[3] + t1, st[2], st[1], st[0], t1 + t2};
  assign load_w = state == PASS0 ? {LEN_640, 320'd0, PAD_ONE, nonce_cur, tail_q} : {LEN_256, 192'd0, PAD_ONE, hbuf};
`ifdef MINER_DIFF_CHECK_EN
  logic [31:0] mask_q;
  assign hit = st[7] == H7_TARGET && ((st[6] + IV[6]) & mask_q) == 32'd0;
`else
  logic diff_mask_unused;
  assign diff_mask_unused = ^diff_mask;
  assign hit = st[7] == H7_TARGET;
`endif
  sha256_rolled_miner_msg_sched u_sched (
    .clk   (clk),
    .load  (ld),
    .shift (rnd),
    .load_w(load_w),
    .w_t   (w_t)
  );
  // Work latch, round registers and first-pass digest buffer (pure datapath, no reset needed)
  always_ff @(posedge clk) begin
    if (start_go) begin
      mid_q <= midstate;
      tail_q <= data_tail;
      end_q <= nonce_end;
`ifdef MINER_DIFF_CHECK_EN
      mask_q <= diff_mask;
`endif
    end
    if (ld) st <= state == PASS0 ? mid_q : IV;
    else if (rnd) st <= st_next;
    if (state == PASS1 && cnt == 7'd0)
      for (int i = 0; i < 8; i++) hbuf[i] <= st[i] + mid_q[i];
  end
  // Sequencer: pass counting, nonce walk, done pulse and golden-nonce handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      skip <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      nonce_cur <= '0;
      golden_valid <= 1'b0;
      golden_nonce <= '0;
      golden_overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (golden_ack) golden_valid <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b1;
      end else if (start_go) begin
        state <= empty ? CHECK : PASS0;
        skip <= empty;
        cnt <= '0;
        busy <= 1'b1;
        nonce_cur <= first[31:0];
        golden_overflow <= 1'b0;
      end else if (state == CHECK) begin
        if (!skip && hit) begin
          if (!golden_valid || golden_ack) begin
            golden_valid <= 1'b1;
            golden_nonce <= nonce_cur;
          end else golden_overflow <= 1'b1;
        end
        if (skip || last) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          state <= PASS0;
          cnt <= '0;
          nonce_cur <= nxt[31:0];
        end
      end else if (hashing) begin
        cnt <= pass_end ? '0 : cnt + 7'd1;
        if (pass_end) state <= state == PASS0 ? PASS1 : CHECK;
      end
    end
  end
endmodule
